// File: rtl/ahbl_to_apb_bridge_if.sv
// Bus bundle for the AHB-Lite to APB3 bridge: AHB-Lite slave port plus APB3 master port.
// An AHB transfer is offered when hready && hsel && htrans[1]; the bridge accepts it only while hready_resp is high,
// and an APB access ends on the ACCESS cycle where pready is high (pslverr qualified by that same cycle).
interface ahbl_to_apb_bridge_if #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16
);
  logic               ahbls_hready;
  logic               ahbls_hready_resp;
  logic               ahbls_hresp;
  logic [W_HADDR-1:0] ahbls_haddr;
  logic               ahbls_hwrite;
  logic [1:0]         ahbls_htrans;
  logic [2:0]         ahbls_hsize;
  logic               ahbls_hsel;
  logic [31:0]        ahbls_hwdata;
  logic [31:0]        ahbls_hrdata;
  logic [W_PADDR-1:0] apbm_paddr;
  logic               apbm_psel;
  logic               apbm_penable;
  logic               apbm_pwrite;
  logic [31:0]        apbm_pwdata;
  logic [31:0]        apbm_prdata;
  logic               apbm_pready;
  logic               apbm_pslverr;

  // slave: the bridge side (AHB slave, APB master)
  modport slave (
    input  ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hsel, ahbls_hwdata,
    output ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    output apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
    input  apbm_prdata, apbm_pready, apbm_pslverr
  );

  // master: the environment side (AHB master, APB peripheral)
  modport master (
    output ahbls_hready, ahbls_haddr, ahbls_hwrite, ahbls_htrans, ahbls_hsize, ahbls_hsel, ahbls_hwdata,
    input  ahbls_hready_resp, ahbls_hresp, ahbls_hrdata,
    input  apbm_paddr, apbm_psel, apbm_penable, apbm_pwrite, apbm_pwdata,
    output apbm_prdata, apbm_pready, apbm_pslverr
  );
endinterface

// File: rtl/ahbl_to_apb_bridge.sv
// Converts one AHB-Lite word transfer at a time into one APB3 SETUP/ACCESS sequence.
// APB inputs only reach AHB outputs through registers or the state register.
module ahbl_to_apb_bridge #(
  parameter int W_HADDR = 32,
  parameter int W_PADDR = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  ahbl_to_apb_bridge_if.slave  bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [W_PADDR-1:0] paddr_q;
  logic               pwrite_q;
  logic [31:0]        pwdata_q;
  logic [31:0]        hrdata_q;
  logic               accept;
  logic               psel, penable, hready_resp, hresp;
  logic               unused_ok;

  // Upper address bits and hsize carry no information here: decode happens upstream, all transfers are words.
  assign unused_ok = ^{bus.ahbls_hsize, bus.ahbls_haddr[W_HADDR-1:W_PADDR]};

  assign accept = ((state_q == S_IDLE) || (state_q == S_ERR2)) &&
                  bus.ahbls_hready && bus.ahbls_hsel && bus.ahbls_htrans[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        paddr_q  <= bus.ahbls_haddr[W_PADDR-1:0];
        pwrite_q <= bus.ahbls_hwrite;
      end
      if (state_q == S_WDATA)
        pwdata_q <= bus.ahbls_hwdata;
      if ((state_q == S_ACCESS) && bus.apbm_pready && !bus.apbm_pslverr && !pwrite_q)
        hrdata_q <= bus.apbm_prdata;
    end
  end

  always_comb begin
    state_d     = state_q;
    psel        = 1'b0;
    penable     = 1'b0;
    hready_resp = 1'b0;
    hresp       = 1'b0;
    case (state_q)
      S_IDLE: begin
        hready_resp = 1'b1;
        if (accept) state_d = bus.ahbls_hwrite ? S_WDATA : S_SETUP;
      end
      S_WDATA: state_d = S_SETUP;
      S_SETUP: begin
        psel    = 1'b1;
        state_d = S_ACCESS;
      end
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        if (bus.apbm_pready) state_d = bus.apbm_pslverr ? S_ERR1 : S_IDLE;
      end
      S_ERR1: begin
        hresp   = 1'b1;
        state_d = S_ERR2;
      end
      S_ERR2: begin
        hresp       = 1'b1;
        hready_resp = 1'b1;
        if (accept) state_d = bus.ahbls_hwrite ? S_WDATA : S_SETUP;
        else        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.ahbls_hready_resp = hready_resp;
  assign bus.ahbls_hresp       = hresp;
  assign bus.ahbls_hrdata      = hrdata_q;
  assign bus.apbm_paddr        = paddr_q;
  assign bus.apbm_psel         = psel;
  assign bus.apbm_penable      = penable;
  assign bus.apbm_pwrite       = pwrite_q;
  assign bus.apbm_pwdata       = pwdata_q;
  assign dbg_state             = state_q;

endmodule

// File: tb/tb_ahbl_to_apb_bridge.sv
// Bench for ahbl_to_apb_bridge: transfers are expanded into the per-cycle bus timeline they must produce,
// and a compare process checks every cycle against that timeline.
module tb_ahbl_to_apb_bridge;

  logic       clk;
  logic       rst;
  logic [2:0] dbg_state;

  ahbl_to_apb_bridge_if #(.W_HADDR(32), .W_PADDR(16)) bus ();

  ahbl_to_apb_bridge #(.W_HADDR(32), .W_PADDR(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        hready_resp;
    logic        hresp;
    logic [15:0] paddr;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] hrdata;
  } exp_t;

  exp_t        exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;

  // transaction-level model state: values the registered outputs must show
  logic [15:0] m_paddr  = '0;
  logic        m_pwrite = 1'b0;
  logic [31:0] m_pwdata = '0;
  logic [31:0] m_hrdata = '0;
  logic        pend_err = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  task automatic push(input logic ps, input logic pe, input logic hr, input logic he);
    exp_t e;
    e.psel        = ps;
    e.penable     = pe;
    e.hready_resp = hr;
    e.hresp       = he;
    e.paddr       = m_paddr;
    e.pwrite      = m_pwrite;
    e.pwdata      = m_pwdata;
    e.hrdata      = m_hrdata;
    exp_q.push_back(e);
  endtask

  // scoreboard compare: one expected record per cycle, checked mid-cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("psel",        {31'd0, bus.apbm_psel},         {31'd0, e.psel});
        chk("penable",     {31'd0, bus.apbm_penable},      {31'd0, e.penable});
        chk("hready_resp", {31'd0, bus.ahbls_hready_resp}, {31'd0, e.hready_resp});
        chk("hresp",       {31'd0, bus.ahbls_hresp},       {31'd0, e.hresp});
        chk("paddr",       {16'd0, bus.apbm_paddr},        {16'd0, e.paddr});
        chk("pwrite",      {31'd0, bus.apbm_pwrite},       {31'd0, e.pwrite});
        chk("pwdata",      bus.apbm_pwdata,                e.pwdata);
        chk("hrdata",      bus.ahbls_hrdata,               e.hrdata);
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ahb_hold();
    bus.ahbls_hready = 1'b0;
    bus.ahbls_hsel   = 1'b1;
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_hwrite = 1'($urandom_range(0, 1));
    bus.ahbls_haddr  = $urandom;
    bus.ahbls_hwdata = $urandom;
  endtask

  task automatic idle_cycle(input logic hsel, input logic [1:0] htrans, input logic hready);
    tick();
    rst              = 1'b0;
    bus.ahbls_hready = hready;
    bus.ahbls_hsel   = hsel;
    bus.ahbls_htrans = htrans;
    bus.ahbls_hwrite = 1'($urandom_range(0, 1));
    bus.ahbls_haddr  = $urandom;
    bus.ahbls_hwdata = $urandom;
    bus.apbm_pready  = 1'b0;
    bus.apbm_pslverr = 1'b0;
    bus.apbm_prdata  = $urandom;
    push(1'b0, 1'b0, 1'b1, pend_err);
    pend_err = 1'b0;
  endtask

  // Address phase is the completion cycle of the previous transfer; ends after the last ACCESS (or ERR1) cycle.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int waits, input logic err);
    tick();
    rst              = 1'b0;
    bus.ahbls_hready = 1'b1;
    bus.ahbls_hsel   = 1'b1;
    bus.ahbls_htrans = 2'($urandom_range(2, 3));
    bus.ahbls_hwrite = wr;
    bus.ahbls_haddr  = addr;
    bus.ahbls_hsize  = 3'($urandom_range(0, 2));
    bus.ahbls_hwdata = $urandom;
    bus.apbm_pready  = 1'b0;
    bus.apbm_pslverr = 1'b0;
    bus.apbm_prdata  = $urandom;
    push(1'b0, 1'b0, 1'b1, pend_err);
    pend_err = 1'b0;
    m_paddr  = addr[15:0];
    m_pwrite = wr;
    if (wr) begin
      tick();
      ahb_hold();
      bus.ahbls_hwdata = wdata;
      bus.apbm_pready  = 1'b1;
      push(1'b0, 1'b0, 1'b0, 1'b0);
      m_pwdata = wdata;
    end
    tick();
    ahb_hold();
    bus.apbm_pready  = 1'b1;
    bus.apbm_pslverr = 1'($urandom_range(0, 1));
    push(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i <= waits; i++) begin
      tick();
      ahb_hold();
      bus.apbm_pready  = (i == waits);
      bus.apbm_pslverr = (i == waits) ? err : 1'($urandom_range(0, 1));
      bus.apbm_prdata  = (i == waits) ? rdata : $urandom;
      push(1'b1, 1'b1, 1'b0, 1'b0);
    end
    if (!wr && !err) m_hrdata = rdata;
    if (err) begin
      tick();
      bus.ahbls_hready = 1'b0;
      bus.ahbls_htrans = 2'b00;
      bus.apbm_pready  = 1'b0;
      bus.apbm_pslverr = 1'b0;
      push(1'b0, 1'b0, 1'b0, 1'b1);
      pend_err = 1'b1;
    end
  endtask

  initial begin
    rst              = 1'b1;
    bus.ahbls_hready = 1'b1;
    bus.ahbls_hsel   = 1'b0;
    bus.ahbls_htrans = 2'b00;
    bus.ahbls_hwrite = 1'b0;
    bus.ahbls_haddr  = '0;
    bus.ahbls_hsize  = 3'b010;
    bus.ahbls_hwdata = '0;
    bus.apbm_prdata  = '0;
    bus.apbm_pready  = 1'b0;
    bus.apbm_pslverr = 1'b0;

    // reset state while reset is held
    tick(); push(1'b0, 1'b0, 1'b1, 1'b0);
    tick(); push(1'b0, 1'b0, 1'b1, 1'b0);

    // read, zero-wait: hrdata valid with hready_resp at A+3
    xfer(1'b0, 32'h4000_0008, 32'h0, 32'h1234_5678, 0, 1'b0);
    idle_cycle(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("pin_read_hrdata", bus.ahbls_hrdata, 32'h1234_5678);
    chk("pin_read_paddr",  {16'd0, bus.apbm_paddr}, 32'h0000_0008);

    // write, zero-wait
    xfer(1'b1, 32'h4000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0);
    idle_cycle(1'b1, 2'b00, 1'b1);
    @(negedge clk);
    chk("pin_write_pwdata", bus.apbm_pwdata, 32'hDEAD_BEEF);
    chk("pin_write_hrdata", bus.ahbls_hrdata, 32'h1234_5678);

    // read with 3 wait states
    xfer(1'b0, 32'h4000_0020, 32'h0, 32'hCAFE_F00D, 3, 1'b0);
    idle_cycle(1'b1, 2'b01, 1'b1);

    // read error, then a read issued in ERR2
    xfer(1'b0, 32'h4000_0030, 32'h0, 32'hBAD0_BAD0, 0, 1'b1);
    @(negedge clk);
    chk("pin_err1_hresp",  {31'd0, bus.ahbls_hresp}, 32'd1);
    chk("pin_err1_hready", {31'd0, bus.ahbls_hready_resp}, 32'd0);
    chk("pin_err_hrdata",  bus.ahbls_hrdata, 32'hCAFE_F00D);
    xfer(1'b0, 32'h4000_0034, 32'h0, 32'h0F0F_0F0F, 1, 1'b0);
    idle_cycle(1'b1, 2'b10, 1'b0);
    @(negedge clk);
    chk("pin_after_err_hrdata", bus.ahbls_hrdata, 32'h0F0F_0F0F);

    // write error, then an idle ERR2
    xfer(1'b1, 32'h4000_0050, 32'h1111_2222, 32'h0, 1, 1'b1);
    idle_cycle(1'b0, 2'b10, 1'b1);

    // back-to-back write then read
    xfer(1'b1, 32'h0000_0000, 32'h0000_0001, 32'h0, 0, 1'b0);
    xfer(1'b0, 32'h0000_0008, 32'h0, 32'h55AA_55AA, 0, 1'b0);
    idle_cycle(1'b0, 2'b00, 1'b1);

    // reset during ACCESS with pready low
    tick();
    bus.ahbls_hready = 1'b1;
    bus.ahbls_hsel   = 1'b1;
    bus.ahbls_htrans = 2'b10;
    bus.ahbls_hwrite = 1'b0;
    bus.ahbls_haddr  = 32'h4000_0044;
    push(1'b0, 1'b0, 1'b1, 1'b0);
    m_paddr  = 16'h0044;
    m_pwrite = 1'b0;
    tick(); ahb_hold(); bus.apbm_pready = 1'b0; push(1'b1, 1'b0, 1'b0, 1'b0);
    tick(); ahb_hold(); bus.apbm_pready = 1'b0; push(1'b1, 1'b1, 1'b0, 1'b0);
    tick(); ahb_hold(); bus.apbm_pready = 1'b0; rst = 1'b1; push(1'b1, 1'b1, 1'b0, 1'b0);
    m_paddr  = '0;
    m_pwrite = 1'b0;
    m_pwdata = '0;
    m_hrdata = '0;
    pend_err = 1'b0;
    idle_cycle(1'b0, 2'b00, 1'b1);
    @(negedge clk);
    chk("pin_rst_psel",  {31'd0, bus.apbm_psel}, 32'd0);
    chk("pin_rst_paddr", {16'd0, bus.apbm_paddr}, 32'd0);
    xfer(1'b0, 32'h4000_0008, 32'h0, 32'h1234_5678, 0, 1'b0);
    idle_cycle(1'b0, 2'b00, 1'b1);
    idle_cycle(1'b0, 2'b00, 1'b1);

    // drain scoreboard, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d records left, want 0", exp_q.size());
    end

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ahbl_to_apb_bridge.md
# ahbl_to_apb_bridge

AHB-Lite slave to APB3 master bridge that feeds the SoC peripheral segment: the RISC-V timer, UART and other APB peripherals sit downstream of it. It takes one AHB-Lite transfer at a time from the system interconnect and converts it into one APB SETUP/ACCESS sequence. The APB read data and error status are returned on the AHB data phase. Every transfer is a full 32-bit word. There is no buffering beyond one transfer.

## Interface
- W_HADDR, default 32: AHB address width.
- W_PADDR, default 16: APB address width; paddr = haddr[W_PADDR-1:0].
- clk  in  1  single clock, shared by the AHB and APB sides.
- rst  in  1  synchronous, active-high reset. One clock; reset is synchronous and active-high.
- ahbls_hready  in  1  bus-level HREADY; qualifies the address phase.
- ahbls_hready_resp  out  1  slave HREADYOUT.
- ahbls_hresp  out  1  1 = ERROR.
- ahbls_haddr  in  W_HADDR  address.
- ahbls_hwrite  in  1  write.
- ahbls_htrans  in  2  transfer type.
- ahbls_hsize  in  3  ignored; every transfer is treated as a word.
- ahbls_hsel  in  1  slave select.
- ahbls_hwdata  in  32  write data, valid in the first data-phase cycle.
- ahbls_hrdata  out  32  read data, registered.
- apbm_paddr  out  W_PADDR  APB address, registered.
- apbm_psel  out  1  APB select.
- apbm_penable  out  1  APB enable.
- apbm_pwrite  out  1  APB write, registered.
- apbm_pwdata  out  32  APB write data, registered.
- apbm_prdata  in  32  APB read data.
- apbm_pready  in  1  APB ready.
- apbm_pslverr  in  1  APB error.

## Operation
- Accept condition: ahbls_hready && ahbls_hsel && ahbls_htrans[1]. It is evaluated only in IDLE or ERR2, which are the only states where hready_resp = 1.
- On accept:
  - Register paddr and pwrite.
  - Go to WDATA if writing, otherwise SETUP.
  - IDLE/BUSY htrans, or hsel = 0: no action, zero-wait OKAY.
- States:
  - IDLE: psel=0, penable=0, hready_resp=1, hresp=0.
  - WDATA: pwdata <= ahbls_hwdata; psel=0, hready_resp=0. Always goes to SETUP next.
  - SETUP: psel=1, penable=0, hready_resp=0. Always goes to ACCESS next.
  - ACCESS: psel=1, penable=1, hready_resp=0.
    - While !pready: stay in ACCESS.
    - pready && !pslverr: hrdata <= prdata (reads only; writes leave hrdata unchanged), go to IDLE.
    - pready && pslverr: go to ERR1.
  - ERR1: hresp=1, hready_resp=0, psel=0. Go to ERR2.
  - ERR2: hresp=1, hready_resp=1, psel=0. May accept a new transfer; otherwise go to IDLE.
- paddr, pwrite and pwdata stay stable from SETUP through the end of ACCESS. They hold their value in IDLE; they are not cleared after a transfer.
- Address is truncated, not decoded; decode is the interconnect's job.
- Write errors are reported the same way as read errors. hrdata is not updated on an error.
- rst (any state, including mid-ACCESS):
  - Next cycle state = IDLE, psel=0, penable=0, hready_resp=1, hresp=0.
  - hrdata=0, paddr=0, pwdata=0, pwrite=0.
  - The aborted APB transfer is not completed.

## Timing
Cycle A is the AHB address phase.
- Read, zero-wait APB:
  - A+1 SETUP, A+2 ACCESS (pready=1), A+3 IDLE.
  - hready_resp=1 and valid hrdata in A+3: 3 data-phase cycles.
- Write, zero-wait APB:
  - A+1 WDATA, A+2 SETUP, A+3 ACCESS, A+4 IDLE: 4 data-phase cycles.
- Each APB cycle with pready low adds one cycle.
- Error: two cycles after the pready && pslverr cycle: ERR1 (hready low), then ERR2 (hready high).
- Back-to-back: the completion cycle (IDLE or ERR2) is the next address phase. psel therefore has at least one low cycle between transfers.
- No combinational path from any APB input to any AHB output.

## Test plan
- Read:
  - Stimulus: haddr=0x4000_0008, prdata=0x1234_5678, pready=1.
  - Required: paddr=0x0008, pwrite=0; psel high A+1..A+2; penable high A+2 only; hrdata=0x1234_5678 with hready_resp=1 at A+3, hresp=0.
- Write:
  - Stimulus: haddr=0x4000_0010, hwdata=0xDEAD_BEEF at A+1.
  - Required: pwdata=0xDEAD_BEEF and pwrite=1 across SETUP (A+2) and ACCESS (A+3); hready_resp=1 at A+4.
- Wait states:
  - Stimulus: read with pready low for 3 ACCESS cycles.
  - Required: paddr, psel and penable constant throughout; hready_resp=1 at A+6.
- Error:
  - Stimulus: read, pready=1, pslverr=1.
  - Required: hresp=1/hready_resp=0 at A+3, hresp=1/hready_resp=1 at A+4; hrdata unchanged; a new read issued at A+4 completes normally.
- Back-to-back:
  - Stimulus: write 0x1 to 0x0 immediately followed by a read of 0x8.
  - Required: second SETUP one cycle after write completion; psel low for exactly one cycle between the two accesses.
- Reset mid-transfer:
  - Stimulus: assert rst during ACCESS with pready=0.
  - Required: next cycle psel=0, penable=0, hready_resp=1, hresp=0, paddr=0; a subsequent read behaves as in the Read scenario.
